// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//    Single-slave APB master. Accepts one command at a time on a valid/ready
//    command channel, runs it as an APB SETUP + ACCESS transfer, and returns
//    the result on a valid/ready response channel. A bounded wait-state
//    counter aborts a transfer whose slave never raises pready, so the
//    requester always gets a response.
//
// Parameters:
//    ADDR_W   - width of cmd_addr / paddr
//    DATA_W   - width of cmd_wdata / rsp_rdata / pwdata / prdata
//    TIMEOUT  - ACCESS cycles allowed without pready before aborting (>= 1)
//
// Ports:
//    pclk, preset              - clock, asynchronous active-high reset
//    cmd_valid / cmd_ready     - command handshake
//    cmd_write, cmd_addr,
//    cmd_wdata                 - command payload (wdata ignored on reads)
//    rsp_valid / rsp_ready     - response handshake
//    rsp_rdata, rsp_err        - read data (0 on writes/timeouts), timeout flag
//    psel, penable, pwrite,
//    paddr, pwdata             - APB request signals (all registered)
//    pready, prdata            - APB completion and read data from the slave
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,

   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   // Counter is wide enough to hold TIMEOUT; it only ever counts up to
   // TIMEOUT-1, so it can never wrap.
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;

   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                rsp_valid_q, rsp_valid_d;

   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;

   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   // Abort condition: slave still stalling on the last allowed ACCESS cycle.
   logic                timeout_hit;
   assign timeout_hit = !pready && (wait_cnt_q == CNT_LAST);

   // ---------------------------------------------------------------------------
   // State register plus the registered control outputs. The control outputs
   // are computed from the next state so that they line up with the state
   // they describe and come out of a flop rather than a state decode.
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. pready is only looked at in ACCESS; if it arrives on
   // the timeout cycle the transfer completes normally.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready || timeout_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: APB phase signals and response valid for the state being
   // entered, so that their flops match the state register every cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_d)
         SETUP: begin
            psel_d = 1'b1;
         end
         ACCESS: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: request capture, wait counter and response latch. The request
   // registers only load in IDLE, so they hold through the whole transfer and
   // keep their last value afterwards. The response registers only load when
   // ACCESS ends, so they stay stable under response back-pressure.
   // ---------------------------------------------------------------------------
   always_comb begin
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      wait_cnt_d  = wait_cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
            end
         end
         SETUP: begin
            wait_cnt_d = '0;
         end
         ACCESS: begin
            if (pready) begin
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               rsp_err_d   = 1'b0;
            end else if (timeout_hit) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         wait_cnt_q  <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         wait_cnt_q  <= wait_cnt_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Command channel is open exactly when no transfer is outstanding.
   assign cmd_ready = (state_q == IDLE);

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign rsp_valid = rsp_valid_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Drives apb_master_bridge (TIMEOUT=4) against a behavioural APB RAM slave with
// a programmable number of wait states, and compares every response with a
// reference model that works only from transfer-level rules: a write returns
// 0, a read returns the last value written, and a slave slower than TIMEOUT
// gives err=1 and no memory update.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;

   logic          pclk = 1'b0;
   logic          preset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;

   int checks = 0;
   int errors = 0;

   // Slave RAM and its wait-state control
   logic [DW-1:0] slave_mem [256];
   logic          mem_init = 1'b1;
   int            slave_waits = 0;
   int            acc_cnt = 0;

   // Reference model memory
   logic [DW-1:0] ref_mem [256];

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            n_acc;
      int            rsp_cyc;
      logic          setup_ok;
      logic          stable_ok;
      logic          timed_out;
   } obs_t;

   apb_master_bridge #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata)
   );

   always #5 pclk = ~pclk;

   // Slave completes after slave_waits stalled ACCESS cycles
   assign pready = psel && penable && (acc_cnt == slave_waits);
   assign prdata = slave_mem[paddr[7:0]];

   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (mem_init) begin
         for (int i = 0; i < 256; i++) slave_mem[i] <= '0;
      end else if (psel && penable && pready && pwrite) begin
         slave_mem[paddr[7:0]] <= pwdata;
      end
   end

   // Transfer-level reference: expected response and ACCESS-cycle count
   task automatic model_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int waits, output logic [DW-1:0] e_rdata, output logic e_err,
                             output int e_acc);
      if (waits >= TO) begin
         e_err   = 1'b1;
         e_rdata = '0;
         e_acc   = TO;
      end else begin
         e_err   = 1'b0;
         e_acc   = waits + 1;
         e_rdata = wr ? '0 : ref_mem[addr[7:0]];
         if (wr) ref_mem[addr[7:0]] = data;
      end
   endtask

   // Issue one command from IDLE (called just after a negedge), observe the
   // transfer cycle by cycle, then consume the response. Cycle 1 is SETUP.
   task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int waits, output obs_t o);
      int n;
      o.setup_ok  = 1'b0;
      o.stable_ok = 1'b1;
      o.timed_out = 1'b1;
      o.n_acc     = 0;
      slave_waits = waits;
      cmd_write   = wr;
      cmd_addr    = addr;
      cmd_wdata   = data;
      cmd_valid   = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      cmd_write = ~wr;
      for (n = 1; n <= 40; n++) begin
         if (n == 1) o.setup_ok = psel && !penable;
         if (psel && penable) begin
            o.n_acc++;
            if (paddr !== addr || pwrite !== wr || (wr && pwdata !== data)) o.stable_ok = 1'b0;
         end
         if (rsp_valid) begin
            o.timed_out = 1'b0;
            break;
         end
         @(negedge pclk);
      end
      o.rsp_cyc = n;
      o.rdata   = rsp_rdata;
      o.err     = rsp_err;
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      preset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge pclk);
      checks++;
      if ({psel, penable, rsp_valid, rsp_err} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000", {psel, penable, rsp_valid, rsp_err});
      end
      checks++;
      if ({pwrite, paddr, pwdata, rsp_rdata} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected all 0", pwrite, paddr, pwdata, rsp_rdata);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      preset = 1'b0;
      @(negedge pclk);
      mem_init = 1'b0;
   endtask

   task automatic test_write_read();
      obs_t o;
      logic [DW-1:0] er;
      logic ee;
      int ea;
      model_xfer(1'b1, 16'h0010, 16'hBEEF, 0, er, ee, ea);
      run_cmd(1'b1, 16'h0010, 16'hBEEF, 0, o);
      checks++;
      if ({o.setup_ok, o.stable_ok, o.timed_out} !== 3'b110 || o.n_acc != ea || o.rsp_cyc != 2 + ea) begin
         errors++;
         $display("[TB] FAIL wr_waveform: got setup=%b stable=%b to=%b acc=%0d rsp_cyc=%0d expected 1/1/0 acc=%0d rsp_cyc=%0d",
                  o.setup_ok, o.stable_ok, o.timed_out, o.n_acc, o.rsp_cyc, ea, 2 + ea);
      end
      checks++;
      if ({o.err, o.rdata} !== {ee, er}) begin
         errors++;
         $display("[TB] FAIL wr_response: got err=%b rdata=%h expected err=%b rdata=%h", o.err, o.rdata, ee, er);
      end
      model_xfer(1'b0, 16'h0010, 16'h0000, 0, er, ee, ea);
      run_cmd(1'b0, 16'h0010, 16'h0000, 0, o);
      checks++;
      if ({o.err, o.rdata} !== {ee, er} || o.n_acc != ea || o.rsp_cyc != 2 + ea) begin
         errors++;
         $display("[TB] FAIL rd_response: got err=%b rdata=%h acc=%0d cyc=%0d expected err=%b rdata=%h acc=%0d cyc=%0d",
                  o.err, o.rdata, o.n_acc, o.rsp_cyc, ee, er, ea, 2 + ea);
      end
   endtask

   task automatic test_wait_states();
      obs_t o;
      logic [DW-1:0] er;
      logic ee;
      int ea;
      model_xfer(1'b1, 16'h0003, 16'h1234, 0, er, ee, ea);
      run_cmd(1'b1, 16'h0003, 16'h1234, 0, o);
      model_xfer(1'b0, 16'h0003, 16'h0000, 2, er, ee, ea);
      run_cmd(1'b0, 16'h0003, 16'h0000, 2, o);
      checks++;
      if (o.n_acc != 3 || o.rsp_cyc != 5 || o.stable_ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wait2_timing: got acc=%0d rsp_cyc=%0d stable=%b expected acc=3 rsp_cyc=5 stable=1",
                  o.n_acc, o.rsp_cyc, o.stable_ok);
      end
      checks++;
      if ({o.err, o.rdata} !== {ee, er}) begin
         errors++;
         $display("[TB] FAIL wait2_data: got err=%b rdata=%h expected err=%b rdata=%h", o.err, o.rdata, ee, er);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      logic [DW-1:0] er;
      logic ee;
      int ea;
      model_xfer(1'b0, 16'h0003, 16'h0000, 1000, er, ee, ea);
      run_cmd(1'b0, 16'h0003, 16'h0000, 1000, o);
      checks++;
      if (o.n_acc != TO || o.rsp_cyc != 2 + TO || {o.err, o.rdata} !== {ee, er}) begin
         errors++;
         $display("[TB] FAIL timeout_abort: got acc=%0d cyc=%0d err=%b rdata=%h expected acc=%0d cyc=%0d err=%b rdata=%h",
                  o.n_acc, o.rsp_cyc, o.err, o.rdata, TO, 2 + TO, ee, er);
      end
      // pready arrives on the last allowed ACCESS cycle
      model_xfer(1'b0, 16'h0003, 16'h0000, TO - 1, er, ee, ea);
      run_cmd(1'b0, 16'h0003, 16'h0000, TO - 1, o);
      checks++;
      if (o.n_acc != TO || {o.err, o.rdata} !== {ee, er}) begin
         errors++;
         $display("[TB] FAIL timeout_pready_wins: got acc=%0d err=%b rdata=%h expected acc=%0d err=%b rdata=%h",
                  o.n_acc, o.err, o.rdata, TO, ee, er);
      end
   endtask

   task automatic test_reset_mid_access();
      logic ok;
      slave_waits = 1000;
      cmd_write   = 1'b0;
      cmd_addr    = 16'h0010;
      cmd_valid   = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      checks++;
      if ({psel, penable} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL midrst_in_access: got psel/penable=%b expected 11", {psel, penable});
      end
      #2 preset = 1'b1;
      #1;
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b000 || paddr !== '0) begin
         errors++;
         $display("[TB] FAIL midrst_async: got psel/penable/rsp_valid=%b paddr=%h expected 000 0000",
                  {psel, penable, rsp_valid}, paddr);
      end
      @(negedge pclk);
      preset = 1'b0;
      ok = 1'b1;
      repeat (8) begin
         @(negedge pclk);
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_no_response: got quiet=%b expected 1", ok);
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      logic [DW-1:0] er;
      logic ee;
      int ea;
      logic ok;
      int n;
      logic [DW-1:0] pend_data;
      model_xfer(1'b1, 16'h0040, 16'hA5A5, 0, er, ee, ea);
      run_cmd(1'b1, 16'h0040, 16'hA5A5, 0, o);
      model_xfer(1'b0, 16'h0040, 16'h0000, 0, er, ee, ea);
      slave_waits = 0;
      cmd_write   = 1'b0;
      cmd_addr    = 16'h0040;
      cmd_valid   = 1'b1;
      @(negedge pclk);
      // pending write held on the command channel from now on
      pend_data = DW'($urandom);
      cmd_write = 1'b1;
      cmd_addr  = 16'h0041;
      cmd_wdata = pend_data;
      for (n = 0; n < 20 && rsp_valid !== 1'b1; n++) @(negedge pclk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_rsp_arrives: got rsp_valid=%b expected 1", rsp_valid);
      end
      ok = 1'b1;
      repeat (5) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0 || cmd_ready !== 1'b0 ||
             psel !== 1'b0 || paddr !== 16'h0040) ok = 1'b0;
         @(negedge pclk);
      end
      checks++;
      if (ok !== 1'b1 || rsp_rdata !== er) begin
         errors++;
         $display("[TB] FAIL bp_hold: got stable=%b rdata=%h expected stable=1 rdata=%h", ok, rsp_rdata, er);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      checks++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL bp_idle_after_hs: got cmd_ready/psel/rsp_valid=%b expected 100", {cmd_ready, psel, rsp_valid});
      end
      @(negedge pclk);
      cmd_valid = 1'b0;
      checks++;
      if ({psel, penable} !== 2'b10 || paddr !== 16'h0041 || pwdata !== pend_data) begin
         errors++;
         $display("[TB] FAIL bp_pending_setup: got psel/penable=%b paddr=%h pwdata=%h expected 10 0041 %h",
                  {psel, penable}, paddr, pwdata, pend_data);
      end
      model_xfer(1'b1, 16'h0041, pend_data, 0, er, ee, ea);
      for (n = 0; n < 20 && rsp_valid !== 1'b1; n++) @(negedge pclk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== {ee, er}) begin
         errors++;
         $display("[TB] FAIL bp_pending_rsp: got valid=%b err=%b rdata=%h expected 1 %b %h", rsp_valid, rsp_err, rsp_rdata, ee, er);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic          c_wr   [8];
      logic [AW-1:0] c_addr [8];
      logic [DW-1:0] c_data [8];
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] er;
      logic ee;
      int ea;
      int idx, nrsp, last_acc, bad_spacing, bad_data, extra;
      logic advance;
      for (int i = 0; i < 8; i++) begin
         c_wr[i]   = (i % 2 == 0);
         c_addr[i] = (i % 2 == 0) ? AW'(2 * (i / 2) + $urandom_range(0, 1)) : c_addr[i - 1];
         c_data[i] = DW'($urandom);
      end
      idx = 0; nrsp = 0; last_acc = -1; bad_spacing = 0; bad_data = 0; extra = 0;
      advance     = 1'b0;
      slave_waits = 0;
      rsp_ready   = 1'b1;
      cmd_write   = c_wr[0];
      cmd_addr    = c_addr[0];
      cmd_wdata   = c_data[0];
      cmd_valid   = 1'b1;
      for (int cyc = 0; cyc < 100 && nrsp < 8; cyc++) begin
         if (advance) begin
            advance = 1'b0;
            if (idx < 8) begin
               cmd_write = c_wr[idx];
               cmd_addr  = c_addr[idx];
               cmd_wdata = c_data[idx];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (rsp_valid) begin
            nrsp++;
            if (exp_q.size() == 0) bad_data++;
            else begin
               er = exp_q.pop_front();
               if (rsp_rdata !== er || rsp_err !== 1'b0) bad_data++;
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (last_acc >= 0 && cyc - last_acc != 4) bad_spacing++;
            last_acc = cyc;
            model_xfer(c_wr[idx], c_addr[idx], c_data[idx], 0, er, ee, ea);
            exp_q.push_back(er);
            idx++;
            advance = 1'b1;
         end
         @(negedge pclk);
      end
      cmd_valid = 1'b0;
      repeat (6) begin
         if (rsp_valid) extra++;
         @(negedge pclk);
      end
      rsp_ready = 1'b0;
      checks++;
      if (nrsp != 8 || extra != 0 || idx != 8) begin
         errors++;
         $display("[TB] FAIL b2b_count: got rsp=%0d extra=%0d accepted=%0d expected 8 0 8", nrsp, extra, idx);
      end
      checks++;
      if (bad_data != 0) begin
         errors++;
         $display("[TB] FAIL b2b_data: got %0d bad responses expected 0", bad_data);
      end
      checks++;
      if (bad_spacing != 0) begin
         errors++;
         $display("[TB] FAIL b2b_spacing: got %0d gaps not equal to 4 expected 0", bad_spacing);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] er;
      logic ee;
      int waits, ea;
      for (int i = 0; i < 24; i++) begin
         wr    = 1'($urandom);
         addr  = AW'(16'h0080 + $urandom_range(0, 7));
         data  = DW'($urandom);
         waits = $urandom_range(0, TO + 1);
         model_xfer(wr, addr, data, waits, er, ee, ea);
         run_cmd(wr, addr, data, waits, o);
         checks++;
         if ({o.err, o.rdata} !== {ee, er} || o.n_acc != ea || o.rsp_cyc != 2 + ea ||
             {o.setup_ok, o.stable_ok, o.timed_out} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rand_%0d: got err=%b rdata=%h acc=%0d cyc=%0d flags=%b expected err=%b rdata=%h acc=%0d cyc=%0d flags=110",
                     i, o.err, o.rdata, o.n_acc, o.rsp_cyc, {o.setup_ok, o.stable_ok, o.timed_out},
                     ee, er, ea, 2 + ea);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      test_reset();
      test_write_read();
      test_wait_states();
      test_timeout();
      test_reset_mid_access();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-slave APB master that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers. It returns each transfer's result on a valid/ready response channel. It sits directly upstream of the APB RAM slave, driving its select, enable, address, write and data signals and consuming its ready and read data. A bounded wait-state timeout protects the requester from a slave that never completes.

## Interface
Parameters:
- ADDR_W, 16, width of paddr and cmd_addr
- DATA_W, 16, width of pwdata, prdata, cmd_wdata and rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles without pready before the transfer is aborted (≥1)

Ports:
- pclk, input, 1, APB clock; the only clock in the block
- preset, input, 1, reset; asynchronous, active-high
- cmd_valid, input, 1, command present
- cmd_ready, output, 1, command accepted when both valid and ready are high at a pclk edge
- cmd_write, input, 1, 1 = write, 0 = read
- cmd_addr, input, ADDR_W, transfer address
- cmd_wdata, input, DATA_W, write data (ignored for reads)
- rsp_valid, output, 1, response present
- rsp_ready, input, 1, response consumed when both valid and ready are high at a pclk edge
- rsp_rdata, output, DATA_W, read data (0 for writes and for timeouts)
- rsp_err, output, 1, transfer aborted by timeout
- psel, output, 1, APB select
- penable, output, 1, APB enable
- pwrite, output, 1, APB direction
- paddr, output, ADDR_W, APB address
- pwdata, output, DATA_W, APB write data
- pready, input, 1, slave completion
- prdata, input, DATA_W, slave read data

## Operation
States: IDLE, SETUP, ACCESS, RESP.

- **IDLE:**
  - cmd_ready=1; psel=0; penable=0.
  - On cmd_valid, capture cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata; go to SETUP.
- **SETUP:**
  - psel=1, penable=0 for exactly one cycle; go to ACCESS.
  - Clear the wait counter.
- **ACCESS:**
  - psel=1, penable=1.
  - pready=1: go to RESP. Latch rsp_rdata = prdata for reads, 0 for writes. rsp_err=0.
  - pready=0 and the wait counter equals TIMEOUT-1: go to RESP with rsp_err=1 and rsp_rdata=0. Otherwise increment the wait counter.
  - If pready=1 on the timeout cycle, the transfer completes normally; pready wins.
- **RESP:**
  - rsp_valid=1; psel=0; penable=0.
  - On rsp_ready, go to IDLE. rsp_rdata and rsp_err hold their values until the next response is latched.

Rules:
- cmd_ready is high only in IDLE.
- pready and prdata are ignored outside ACCESS.
- paddr, pwrite and pwdata are registered. They stay stable from SETUP through the last ACCESS cycle and keep their values in RESP and IDLE until the next command is captured.
- The wait counter is $clog2(TIMEOUT+1) bits wide and never wraps; it is cleared in SETUP.
- Only one transfer is ever outstanding.

## Timing
- **Reset:** asserting preset at any time forces state to IDLE and all registered outputs to 0 (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err). cmd_ready=1 while in IDLE, including during reset. A transfer interrupted by reset is dropped with no response.
- **Cycle numbering** (edge n ends cycle n):
  - Command accepted at edge 0.
  - SETUP is cycle 1.
  - ACCESS starts in cycle 2.
  - With a zero-wait slave, pready=1 in cycle 2; rsp_valid=1 in cycle 3.
- **Throughput:** with rsp_ready held high the state returns to IDLE in cycle 4, so the minimum spacing is 4 cycles per transfer.
- **Wait states:** each wait state adds one ACCESS cycle.
- **Timeout:** the last ACCESS cycle is cycle 2+TIMEOUT-1, and RESP is entered one cycle later.
- **Response back-pressure:** rsp_valid stays high with stable data while rsp_ready=0. No new command is accepted during that time.
- A command offered while cmd_ready=0 is not consumed; the requester must hold it.

## Test plan
- Reset mid-ACCESS: raise preset in cycle 2 → psel, penable and rsp_valid go to 0 immediately. After release, cmd_ready=1 and no response is produced.
- Write then read with a zero-wait RAM slave:
  - Write addr 0x0010, data 0xBEEF → psel and penable waveform is SETUP then one ACCESS cycle. The response has rsp_err=0 and rsp_rdata=0x0000.
  - Read addr 0x0010 → rsp_rdata=0xBEEF.
- Slave with 2 wait states: read addr 0x0003 holding 0x1234 → three ACCESS cycles, paddr stable at 0x0003 throughout, rsp_valid in cycle 5, rsp_rdata=0x1234.
- Timeout with TIMEOUT=4 and pready tied low → exactly 4 ACCESS cycles, then rsp_err=1 and rsp_rdata=0. A second case raises pready in the 4th ACCESS cycle → rsp_err=0.
- Response back-pressure: hold rsp_ready=0 for 5 cycles after a read of 0xA5A5 → rsp_valid and rsp_rdata stay stable, cmd_ready=0, and a pending cmd_valid is not accepted until one cycle after the rsp handshake.
- Back-to-back stream of 8 alternating write and read commands to addresses 0x0000–0x0007 with rsp_ready=1 → each read returns the data just written. Transfers are spaced 4 cycles apart and no response is lost or duplicated.
